// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and recovery sequencer, clocked from the reference crystal.
// Pulses PLL reset, waits for a stable LOCK, then releases the downstream reset tree.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_pll_lock,
  input  logic       in_force_relock,
  output logic       out_pll_reset,
  output logic       out_sys_reset,
  output logic       out_ready,
  output logic       out_fault,
  output logic [3:0] out_retry_count,
  output logic [7:0] out_loss_count
);

  localparam int MAX_SPAN_A = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_SPAN   = (MAX_SPAN_A > PLL_RESET_CYCLES) ? MAX_SPAN_A : PLL_RESET_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_SPAN + 1) > 19) ? $clog2(MAX_SPAN + 1) : 19;

  localparam logic [CNT_W-1:0] PLL_RESET_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The entry cycle plus a full window of lock samples: release lands at
  // LOCK_STABLE_CYCLES+3 edges after the synchronizer first samples LOCK.
  localparam logic [CNT_W-1:0] STABLE_LAST    = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [3:0]       RETRY_LIMIT    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, sync2_q;
  logic             lock;
  logic             restart;
  logic             timed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make the second sync flop a wire.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_pll_lock;
      sync2_q <= sync1_q;
    end
  end

  assign lock = sync2_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    restart = 1'b0;
    if (in_force_relock) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == PLL_RESET_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock) begin
            state_d = S_STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
          end
        end
        S_STABILIZE: begin
          if (!lock)                     state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            retry_d = '0;
            state_d = S_RESET_PLL;
          end
        end
        S_FAULT: ;
        default: state_d = S_RESET_PLL;
      endcase
    end

    timed = (state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) || (state_q == S_STABILIZE);
    if (restart || (state_d != state_q)) cnt_d = '0;
    else if (timed)                      cnt_d = cnt_q + 1'b1;
    else                                 cnt_d = cnt_q;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q         <= S_RESET_PLL;
      cnt_q           <= '0;
      retry_q         <= '0;
      loss_q          <= '0;
      out_pll_reset   <= 1'b1;
      out_sys_reset   <= 1'b1;
      out_ready       <= 1'b0;
      out_fault       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      loss_q          <= loss_d;
      out_pll_reset   <= (state_d == S_RESET_PLL);
      out_sys_reset   <= (state_d != S_RUN);
      out_ready       <= (state_d == S_RUN);
      out_fault       <= (state_d == S_FAULT);
    end
  end

  assign out_retry_count = retry_q;
  assign out_loss_count  = loss_q;

endmodule
